// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// rd_data whenever the FIFO holds data. The FIFO also reports occupancy,
// almost-full/almost-empty levels and sticky overflow/underflow error flags.
// Extra-MSB pointers make all 2**ADDR_WIDTH entries usable.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(AE_LEVEL);

    // Storage; never reset, so stale contents after a reset are simply unreachable.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q,  count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic empty_w;
    logic full_w;
    logic wr_acc;
    logic rd_acc;

    // Status decoded purely from the pointers so it never depends on count.
    always_comb begin
        empty_w = (wr_ptr_q == rd_ptr_q);
        full_w  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
        // A full FIFO never writes through and an empty FIFO never bypasses.
        wr_acc  = wr_en && !full_w;
        rd_acc  = rd_en && !empty_w;
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase

        // Clear first so that an error in the same cycle as clr_err still sticks.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full_w) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty_w) begin
            underflow_d = 1'b1;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge sys_clock) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write port; only accepted writes touch the array.
    always_ff @(posedge sys_clock) begin
        if (reset && wr_acc) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Output decode: head data falls through combinationally from the read pointer.
    always_comb begin
        empty        = empty_w;
        full         = full_w;
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
        almost_full  = (count_q >= AF_CNT);
        almost_empty = (count_q <= AE_CNT);
        rd_data      = empty_w ? '0 : mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

endmodule
